// File: rtl/life_engine_if.sv
// Control and pixel-read bundle between the Life engine and its
// frame/renderer side.
interface life_engine_if #(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8,
    parameter int GEN_W   = 16
);
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);

    logic             frame_tick;
    logic             run;
    logic             step;
    logic             clear;
    logic             seed_load;
    logic [XW-1:0]    rd_x;
    logic [YW-1:0]    rd_y;
    logic             rd_cell;
    logic             busy;
    logic [GEN_W-1:0] gen_count;

    modport master (
        output frame_tick, run, step, clear, seed_load, rd_x, rd_y,
        input  rd_cell, busy, gen_count
    );

    modport slave (
        input  frame_tick, run, step, clear, seed_load, rd_x, rd_y,
        output rd_cell, busy, gen_count
    );
endinterface

// File: rtl/life_engine.sv
// Game of Life engine: double-buffered board, one cell per clock
// sweep, committed to the display buffer once per generation.
module life_engine #(
    parameter int BOARD_W        = 8,
    parameter int BOARD_H        = 8,
    parameter int WRAP           = 0,
    parameter int FRAMES_PER_GEN = 1,
    parameter int GEN_W          = 16,
    parameter logic [BOARD_W*BOARD_H-1:0] SEED = 'h38
) (
    input logic          clk,
    input logic          rst_n,
    life_engine_if.slave bus
);
    localparam int SIZE = BOARD_W * BOARD_H;
    localparam int IW   = $clog2(SIZE);
    localparam int XW   = $clog2(BOARD_W);
    localparam int YW   = $clog2(BOARD_H);
    localparam int DW   = $clog2(FRAMES_PER_GEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SIZE-1:0]  disp;
    logic [SIZE-1:0]  nxt;
    logic [IW-1:0]    idx;
    logic [XW-1:0]    cx;
    logic [YW-1:0]    cy;
    logic [DW-1:0]    div;
    logic             step_pend;
    logic [GEN_W-1:0] gen;
    logic             div_go;
    logic             start;
    logic             last;
    logic             cell_new;
    logic [3:0]       ncount;
    int               nx;
    int               ny;

    assign div_go = bus.run && bus.frame_tick &&
                    (div == DW'(FRAMES_PER_GEN - 1));
    assign start  = (state == IDLE) && bus.frame_tick &&
                    (div_go || step_pend);
    assign last   = (idx == IW'(SIZE - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Neighbour coordinates use full-width compares so non-power-of-2
    // boards wrap or clip correctly.
    always_comb begin
        ncount = '0;
        nx     = 0;
        ny     = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(cx) + dx;
                ny = int'(cy) + dy;
                if (WRAP != 0) begin
                    if (nx < 0) nx = BOARD_W - 1;
                    else if (nx >= BOARD_W) nx = 0;
                    if (ny < 0) ny = BOARD_H - 1;
                    else if (ny >= BOARD_H) ny = 0;
                end
                if (!(dx == 0 && dy == 0) &&
                    nx >= 0 && nx < BOARD_W &&
                    ny >= 0 && ny < BOARD_H)
                    ncount = ncount +
                             {3'b000, disp[IW'(ny * BOARD_W + nx)]};
            end
        end
    end

    assign cell_new = disp[idx] ? (ncount == 4'd2 || ncount == 4'd3)
                                : (ncount == 4'd3);

    always_comb begin
        bus.rd_cell = 1'b0;
        if (int'(bus.rd_x) < BOARD_W && int'(bus.rd_y) < BOARD_H)
            bus.rd_cell = disp[IW'(int'(bus.rd_y) * BOARD_W +
                                   int'(bus.rd_x))];
    end

    assign bus.busy      = (state == CALC);
    assign bus.gen_count = gen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            disp      <= SEED;
            nxt       <= '0;
            idx       <= '0;
            cx        <= '0;
            cy        <= '0;
            div       <= '0;
            step_pend <= 1'b0;
            gen       <= '0;
        end else if (bus.clear || bus.seed_load) begin
            state     <= IDLE;
            disp      <= bus.clear ? '0 : SEED;
            nxt       <= '0;
            idx       <= '0;
            cx        <= '0;
            cy        <= '0;
            div       <= '0;
            step_pend <= 1'b0;
            gen       <= '0;
        end else begin
            state <= state_nxt;
            if (!bus.run)
                div <= '0;
            else if (bus.frame_tick)
                div <= div_go ? '0 : div + 1'b1;
            if (start)
                step_pend <= 1'b0;
            else if (bus.step)
                step_pend <= 1'b1;
            if (start) begin
                idx <= '0;
                cx  <= '0;
                cy  <= '0;
            end
            if (state == CALC) begin
                nxt[idx] <= cell_new;
                idx      <= idx + 1'b1;
                if (cx == XW'(BOARD_W - 1)) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
            if (state == COMMIT) begin
                disp <= nxt;
                gen  <= gen + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: three boards (8x8 clipped, 8x8 toroidal
// with frame divider, 5x7 toroidal glider) against a software model.
module tb_life_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic run = 1'b0;
    logic step = 1'b0;
    logic clear = 1'b0;
    logic seed_load = 1'b0;
    logic [2:0] rd_x = '0;
    logic [2:0] rd_y = '0;

    int checks = 0;
    int errors = 0;

    localparam int MW[3] = '{8, 8, 5};
    localparam int MH[3] = '{8, 8, 7};
    localparam bit MWRAP[3] = '{1'b0, 1'b1, 1'b1};
    localparam int MFPG[3] = '{1, 4, 1};
    localparam logic [63:0] MSEED[3] = '{64'h38, 64'h38, 64'h1C82};

    logic [63:0] mb[3];
    logic [15:0] mgen[3];
    int          mdiv[3];
    bit          mpend[3];
    bit          mrun;

    logic [63:0] rb[3];
    logic [15:0] rg[3];
    logic        rbusy[3];
    logic        oob_bad;

    always #5 clk = ~clk;

    life_engine_if #(.BOARD_W(8), .BOARD_H(8), .GEN_W(16)) ifa ();
    life_engine_if #(.BOARD_W(8), .BOARD_H(8), .GEN_W(16)) ifb ();
    life_engine_if #(.BOARD_W(5), .BOARD_H(7), .GEN_W(16)) ifc ();

    assign ifa.frame_tick = frame_tick;
    assign ifa.run = run;
    assign ifa.step = step;
    assign ifa.clear = clear;
    assign ifa.seed_load = seed_load;
    assign ifa.rd_x = rd_x;
    assign ifa.rd_y = rd_y;
    assign ifb.frame_tick = frame_tick;
    assign ifb.run = run;
    assign ifb.step = step;
    assign ifb.clear = clear;
    assign ifb.seed_load = seed_load;
    assign ifb.rd_x = rd_x;
    assign ifb.rd_y = rd_y;
    assign ifc.frame_tick = frame_tick;
    assign ifc.run = run;
    assign ifc.step = step;
    assign ifc.clear = clear;
    assign ifc.seed_load = seed_load;
    assign ifc.rd_x = rd_x;
    assign ifc.rd_y = rd_y;

    life_engine #(
        .BOARD_W(8), .BOARD_H(8), .WRAP(0), .FRAMES_PER_GEN(1),
        .GEN_W(16), .SEED(64'h38)
    ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    life_engine #(
        .BOARD_W(8), .BOARD_H(8), .WRAP(1), .FRAMES_PER_GEN(4),
        .GEN_W(16), .SEED(64'h38)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    life_engine #(
        .BOARD_W(5), .BOARD_H(7), .WRAP(1), .FRAMES_PER_GEN(1),
        .GEN_W(16), .SEED(35'h1C82)
    ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Reference: Conway's rule applied to the whole board at once.
    function automatic logic [63:0] life_next(logic [63:0] b, int w,
                                              int h, bit wr);
        logic [63:0] r;
        int n, xx, yy;
        r = '0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        xx = x + dx;
                        yy = y + dy;
                        if (wr) begin
                            xx = (xx + w) % w;
                            yy = (yy + h) % h;
                        end
                        if (xx >= 0 && xx < w && yy >= 0 && yy < h)
                            n += int'(b[yy * w + xx]);
                    end
                end
                r[y * w + x] = (n == 3) || (b[y * w + x] && n == 2);
            end
        end
        return r;
    endfunction

    function automatic void model_reset(bit to_seed);
        for (int d = 0; d < 3; d++) begin
            mb[d] = to_seed ? MSEED[d] : 64'h0;
            mgen[d] = '0;
            mdiv[d] = 0;
            mpend[d] = 1'b0;
        end
    endfunction

    function automatic void model_tick();
        bit go;
        for (int d = 0; d < 3; d++) begin
            go = 1'b0;
            if (mrun) begin
                mdiv[d]++;
                if (mdiv[d] == MFPG[d]) begin
                    go = 1'b1;
                    mdiv[d] = 0;
                end
            end else begin
                mdiv[d] = 0;
            end
            if (go || mpend[d]) begin
                mpend[d] = 1'b0;
                mb[d] = life_next(mb[d], MW[d], MH[d], MWRAP[d]);
                mgen[d] = mgen[d] + 16'd1;
            end
        end
    endfunction

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        tick_clk(1);
        frame_tick = 1'b0;
        model_tick();
    endtask

    task automatic do_step();
        step = 1'b1;
        tick_clk(1);
        step = 1'b0;
        for (int d = 0; d < 3; d++) mpend[d] = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick_clk(1);
        clear = 1'b0;
        model_reset(1'b0);
    endtask

    task automatic do_seed();
        seed_load = 1'b1;
        tick_clk(1);
        seed_load = 1'b0;
        model_reset(1'b1);
    endtask

    task automatic set_run(input bit r);
        run = r;
        mrun = r;
        if (!r) for (int d = 0; d < 3; d++) mdiv[d] = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((ifa.busy || ifb.busy || ifc.busy) && n < 300) begin
            tick_clk(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s idle_timeout cycles %0d limit 300", tag, n);
        end
        tick_clk(2);
    endtask

    task automatic read_boards();
        oob_bad = 1'b0;
        for (int d = 0; d < 3; d++) rb[d] = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                rd_x = 3'(x);
                rd_y = 3'(y);
                #1;
                rb[0][y * 8 + x] = ifa.rd_cell;
                rb[1][y * 8 + x] = ifb.rd_cell;
                if (x < 5 && y < 7) rb[2][y * 5 + x] = ifc.rd_cell;
                else if (ifc.rd_cell !== 1'b0) oob_bad = 1'b1;
            end
        end
        rg[0] = ifa.gen_count;
        rg[1] = ifb.gen_count;
        rg[2] = ifc.gen_count;
        rbusy[0] = ifa.busy;
        rbusy[1] = ifb.busy;
        rbusy[2] = ifc.busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_clk(2);
        rst_n = 1'b1;
        set_run(1'b0);
        model_reset(1'b1);
        tick_clk(1);
        read_boards();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rb[d] !== MSEED[d] || rg[d] !== 16'd0 || rbusy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d board %h gen %0d busy %b expected %h 0 0",
                         d, rb[d], rg[d], rbusy[d], MSEED[d]);
            end
        end
        checks++;
        if (oob_bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_oob_read got %b expected 0", oob_bad);
        end
    endtask

    task automatic test_step_latency();
        int n = 0;
        do_step();
        rd_x = 3'd3;
        rd_y = 3'd0;
        do_tick();
        while (ifa.busy && n < 200) begin
            n++;
            tick_clk(1);
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL busy_width got %0d cycles expected 64", n);
        end
        checks++;
        if (ifa.rd_cell !== 1'b1) begin
            errors++;
            $display("FAIL pre_commit cell3 got %b expected 1", ifa.rd_cell);
        end
        tick_clk(1);
        checks++;
        if (ifa.rd_cell !== 1'b0) begin
            errors++;
            $display("FAIL post_commit cell3 got %b expected 0", ifa.rd_cell);
        end
        wait_idle("step1");
        read_boards();
        checks++;
        if (rb[0] !== 64'h1010 || rb[1] !== 64'h1000_0000_0000_1010) begin
            errors++;
            $display("FAIL step1_boards got %h %h expected 1010 1000000000001010",
                     rb[0], rb[1]);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rb[d] !== mb[d] || rg[d] !== mgen[d]) begin
                errors++;
                $display("FAIL step1 dut%0d board %h gen %0d expected %h %0d",
                         d, rb[d], rg[d], mb[d], mgen[d]);
            end
        end
        do_step();
        do_tick();
        wait_idle("step2");
        read_boards();
        checks++;
        if (rb[0] !== 64'h0 || rb[1] !== 64'h38 || rg[0] !== 16'd2) begin
            errors++;
            $display("FAIL step2_boards got %h %h gen %0d expected 0 38 2",
                     rb[0], rb[1], rg[0]);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rb[d] !== mb[d] || rg[d] !== mgen[d]) begin
                errors++;
                $display("FAIL step2 dut%0d board %h gen %0d expected %h %0d",
                         d, rb[d], rg[d], mb[d], mgen[d]);
            end
        end
    endtask

    task automatic test_run_divider();
        do_seed();
        set_run(1'b1);
        for (int t = 0; t < 8; t++) begin
            do_tick();
            wait_idle("run");
            read_boards();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rb[d] !== mb[d] || rg[d] !== mgen[d]) begin
                    errors++;
                    $display("FAIL run tick%0d dut%0d board %h gen %0d expected %h %0d",
                             t, d, rb[d], rg[d], mb[d], mgen[d]);
                end
            end
        end
        checks++;
        if (rg[1] !== 16'd2 || rb[1] !== 64'h38 || rg[2] !== 16'd8) begin
            errors++;
            $display("FAIL run_divider gen %0d board %h glider_gen %0d expected 2 38 8",
                     rg[1], rb[1], rg[2]);
        end
        set_run(1'b0);
    endtask

    task automatic test_clear_mid_calc();
        do_seed();
        do_step();
        do_tick();
        tick_clk(30);
        do_clear();
        checks++;
        if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0 || ifc.busy !== 1'b0 ||
            ifa.gen_count !== 16'd0 || ifc.gen_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_abort busy %b%b%b gen %0d expected 000 0",
                     ifa.busy, ifb.busy, ifc.busy, ifa.gen_count);
        end
        tick_clk(2);
        read_boards();
        checks++;
        if (rb[0] !== 64'h0 || rb[1] !== 64'h0 || rb[2] !== 64'h0) begin
            errors++;
            $display("FAIL clear_board got %h %h %h expected 0",
                     rb[0], rb[1], rb[2]);
        end
        do_tick();
        wait_idle("clear");
        read_boards();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rb[d] !== mb[d] || rg[d] !== mgen[d] || rg[d] !== 16'd0) begin
                errors++;
                $display("FAIL clear_idle dut%0d board %h gen %0d expected %h 0",
                         d, rb[d], rg[d], mb[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_seed();
        do_step();
        do_tick();
        tick_clk(3);
        do_step();
        tick_clk(3);
        do_step();
        wait_idle("b2b0");
        for (int t = 0; t < 2; t++) begin
            do_tick();
            wait_idle("b2b");
            read_boards();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rb[d] !== mb[d] || rg[d] !== mgen[d]) begin
                    errors++;
                    $display("FAIL b2b tick%0d dut%0d board %h gen %0d expected %h %0d",
                             t, d, rb[d], rg[d], mb[d], mgen[d]);
                end
            end
        end
        checks++;
        if (rg[2] !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count gen %0d expected 2", rg[2]);
        end
    endtask

    task automatic test_reset_mid_calc();
        do_step();
        do_tick();
        tick_clk(10);
        rst_n = 1'b0;
        tick_clk(1);
        rst_n = 1'b1;
        model_reset(1'b1);
        checks++;
        if (ifa.busy !== 1'b0 || ifc.busy !== 1'b0 || ifa.gen_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid busy %b%b gen %0d expected 00 0",
                     ifa.busy, ifc.busy, ifa.gen_count);
        end
        do_tick();
        wait_idle("rstmid");
        read_boards();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rb[d] !== MSEED[d] || rg[d] !== mgen[d]) begin
                errors++;
                $display("FAIL reset_mid dut%0d board %h gen %0d expected %h %0d",
                         d, rb[d], rg[d], MSEED[d], mgen[d]);
            end
        end
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 5) begin
                do_step();
                do_tick();
            end else if (op <= 9) begin
                set_run(1'($urandom_range(0, 1)));
                do_tick();
            end else if (op == 10) begin
                do_seed();
            end else begin
                do_clear();
            end
            wait_idle("rand");
            read_boards();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rb[d] !== mb[d] || rg[d] !== mgen[d]) begin
                    errors++;
                    $display("FAIL rand it%0d op%0d dut%0d board %h gen %0d expected %h %0d",
                             it, op, d, rb[d], rg[d], mb[d], mgen[d]);
                end
            end
            checks++;
            if (oob_bad !== 1'b0) begin
                errors++;
                $display("FAIL rand_oob it%0d got %b expected 0", it, oob_bad);
            end
        end
        set_run(1'b0);
    endtask

    initial begin
        test_reset();
        test_step_latency();
        test_run_divider();
        test_clear_mid_calc();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
